// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the sequential 2-D convolution engine.
package conv2d_pkg;

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

    // Widest accumulator the saturate helper accepts. Callers sign-extend into it.
    localparam int SAT_W = 64;

    function automatic int out_dim(int in_sz, int k, int s, int p);
        return (in_sz + 2 * p - k) / s + 1;
    endfunction

    // Clamp a sign-extended accumulator to the signed range of data_w bits.
    function automatic logic signed [SAT_W-1:0] saturate(logic signed [SAT_W-1:0] acc,
                                                         int data_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi)      return hi;
        else if (acc < lo) return lo;
        else               return acc;
    endfunction

endpackage

// File: rtl/conv2d_seq_engine_if.sv
// Start/status and result stream between the convolution engine and its neighbours.
interface conv2d_seq_engine_if #(parameter int DATA_WIDTH = 16);
    logic                  start;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  done;

    modport master (output start, out_ready,
                    input  busy, out_valid, out_data, out_last, done);
    modport slave  (input  start, out_ready,
                    output busy, out_valid, out_data, out_last, done);
endinterface

// File: rtl/conv2d_mac.sv
// Signed accumulator: clr loads bias plus the first product, en adds a product.
module conv2d_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [DATA_WIDTH-1:0]  bias,
    input  logic signed [2*DATA_WIDTH-1:0] prod,
    output logic signed [ACC_WIDTH-1:0]   acc
);
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
    logic signed [ACC_WIDTH-1:0] bias_ext, prod_ext;

    assign bias_ext = ACC_WIDTH'(bias);
    assign prod_ext = ACC_WIDTH'(prod);

    always_comb begin
        acc_d = acc_q;
        if (clr)     acc_d = bias_ext + prod_ext;
        else if (en) acc_d = acc_q + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/conv2d_seq_engine.sv
// One-MAC-per-cycle multi-channel 2-D convolution with bias and a valid/ready result stream.
// Optional CONV2D_SEQ_RELU_EN: apply ReLU to the clamped result.
module conv2d_seq_engine
    import conv2d_pkg::*;
#(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]                  input_tensor_flat,
    input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                    bias_flat,
    conv2d_seq_engine_if.slave io
);
    localparam int OUT_H = out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
    localparam int OUT_W = out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING);
    localparam int IN_BITS = IN_CHANNELS * IN_HEIGHT * IN_WIDTH * DATA_WIDTH;
    localparam int W_BITS  = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
    localparam int B_BITS  = OUT_CHANNELS * DATA_WIDTH;

    state_t state_d, state_q;
    logic   go_d, go_q;
    int     oc_d, oc_q, oh_d, oh_q, ow_d, ow_q;
    int     ic_d, ic_q, kh_d, kh_q, kw_d, kw_q;
    logic [IN_BITS-1:0] in_d, in_q;
    logic [W_BITS-1:0]  w_d, w_q;
    logic [B_BITS-1:0]  b_d, b_q;

    int   ih, iw, in_idx, w_idx;
    logic in_rng, first_term, last_term, last_out;
    logic mac_clr, mac_en;
    logic signed [DATA_WIDTH-1:0]   x_op, w_op, b_op, sat;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc;

    // Current term's operand addresses; padded taps read as zero.
    always_comb begin
        ih     = oh_q * STRIDE + kh_q - PADDING;
        iw     = ow_q * STRIDE + kw_q - PADDING;
        in_rng = (ih >= 0) && (ih < IN_HEIGHT) && (iw >= 0) && (iw < IN_WIDTH);
        in_idx = in_rng ? (ic_q * IN_HEIGHT + ih) * IN_WIDTH + iw : 0;
        w_idx  = ((oc_q * IN_CHANNELS + ic_q) * KERNEL_SIZE + kh_q) * KERNEL_SIZE + kw_q;
        x_op   = in_rng ? in_q[in_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        w_op   = w_q[w_idx*DATA_WIDTH +: DATA_WIDTH];
        b_op   = b_q[oc_q*DATA_WIDTH +: DATA_WIDTH];
    end

    assign prod       = x_op * w_op;
    assign first_term = (ic_q == 0) && (kh_q == 0) && (kw_q == 0);
    assign last_term  = (ic_q == IN_CHANNELS - 1) && (kh_q == KERNEL_SIZE - 1) &&
                        (kw_q == KERNEL_SIZE - 1);
    assign last_out   = (oc_q == OUT_CHANNELS - 1) && (oh_q == OUT_H - 1) && (ow_q == OUT_W - 1);

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        oc_d = oc_q; oh_d = oh_q; ow_d = ow_q;
        ic_d = ic_q; kh_d = kh_q; kw_d = kw_q;
        in_d = in_q; w_d = w_q; b_d = b_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // Operands are latched on the accepting edge; the run starts one cycle later.
                if (go_q) begin
                    go_d    = 1'b0;
                    oc_d = 0; oh_d = 0; ow_d = 0;
                    ic_d = 0; kh_d = 0; kw_d = 0;
                    state_d = MAC;
                end else if (io.start) begin
                    go_d = 1'b1;
                    in_d = input_tensor_flat;
                    w_d  = weights_flat;
                    b_d  = bias_flat;
                end
            end
            MAC: begin
                mac_clr = first_term;
                mac_en  = !first_term;
                if (kw_q == KERNEL_SIZE - 1) begin
                    kw_d = 0;
                    if (kh_q == KERNEL_SIZE - 1) begin
                        kh_d = 0;
                        ic_d = (ic_q == IN_CHANNELS - 1) ? 0 : ic_q + 1;
                    end else begin
                        kh_d = kh_q + 1;
                    end
                end else begin
                    kw_d = kw_q + 1;
                end
                if (last_term) state_d = EMIT;
            end
            EMIT: begin
                if (io.out_ready) begin
                    if (last_out) begin
                        state_d = DONE;
                    end else begin
                        state_d = MAC;
                        if (ow_q == OUT_W - 1) begin
                            ow_d = 0;
                            if (oh_q == OUT_H - 1) begin
                                oh_d = 0;
                                oc_d = oc_q + 1;
                            end else begin
                                oh_d = oh_q + 1;
                            end
                        end else begin
                            ow_d = ow_q + 1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            oc_q <= 0; oh_q <= 0; ow_q <= 0;
            ic_q <= 0; kh_q <= 0; kw_q <= 0;
            in_q <= '0; w_q <= '0; b_q <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            oc_q <= oc_d; oh_q <= oh_d; ow_q <= ow_d;
            ic_q <= ic_d; kh_q <= kh_d; kw_q <= kw_d;
            in_q <= in_d; w_q <= w_d; b_q <= b_d;
        end
    end

    conv2d_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (mac_en),
        .bias (b_op),
        .prod (prod),
        .acc  (acc)
    );

    assign sat = DATA_WIDTH'(saturate(SAT_W'(acc), DATA_WIDTH));

    always_comb begin
        io.out_data = '0;
        if (state_q == EMIT) begin
`ifdef CONV2D_SEQ_RELU_EN
            io.out_data = sat[DATA_WIDTH-1] ? '0 : sat;
`else
            io.out_data = sat;
`endif
        end
    end

    assign io.busy      = (state_q != IDLE);
    assign io.out_valid = (state_q == EMIT);
    assign io.out_last  = (state_q == EMIT) && last_out;
    assign io.done      = (state_q == DONE);
endmodule
